// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS-subset CPU (add/sub/and/or/slt, lw/sw, beq, addi, j)
// driving one shared memory port with a ready handshake so wait states are tolerated.
module mips_multicycle_core #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic                  halt,
    output logic [ADDR_WIDTH-1:0] pc
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_ILLEGAL
    } state_t;
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
    logic [31:0] r_rf [32];
    logic [31:0] w_simm, w_addr, w_alu, w_rf_wd;
    logic [4:0]  w_rf_wa;
    logic        w_rf_we, w_funct_ok;
    assign w_simm = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_addr = r_a + w_simm;
    always_comb begin
        w_alu      = '0;
        w_funct_ok = 1'b1;
        case (r_ir[5:0])
            6'h20:   w_alu = r_a + r_b;
            6'h22:   w_alu = r_a - r_b;
            6'h24:   w_alu = r_a & r_b;
            6'h25:   w_alu = r_a | r_b;
            6'h2A:   w_alu = {31'b0, $signed(r_a) < $signed(r_b)};
            default: w_funct_ok = 1'b0;
        endcase
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: case (r_ir[31:26])
                6'h23, 6'h2B: w_next = S_MEMADR;
                6'h00:        w_next = S_EXEC;
                6'h04:        w_next = S_BRANCH;
                6'h08:        w_next = S_ADDIEX;
                6'h02:        w_next = S_JUMP;
                default:      w_next = S_ILLEGAL;
            endcase
            S_MEMADR: w_next = (w_addr[1:0] != 2'b00) ? S_ILLEGAL :
                               (r_ir[31:26] == 6'h23) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = w_funct_ok ? S_ALUWB : S_ILLEGAL;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
            default:  w_next = r_state;
        endcase
    end
    // Bus outputs are pure state decodes, forced quiet while reset is held.
    assign mem_re    = !reset && (r_state == S_FETCH || r_state == S_MEMRD);
    assign mem_we    = !reset && (r_state == S_MEMWR);
    assign halt      = !reset && (r_state == S_ILLEGAL);
    assign mem_addr  = (r_state == S_MEMRD || r_state == S_MEMWR) ? r_aluout[ADDR_WIDTH-1:0] : r_pc[ADDR_WIDTH-1:0];
    assign mem_wdata = r_b;
    assign pc        = r_pc[ADDR_WIDTH-1:0];
    assign w_rf_we   = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_ADDIWB);
    assign w_rf_wa   = (r_state == S_ALUWB) ? r_ir[15:11] : r_ir[20:16];
    assign w_rf_wd   = (r_state == S_MEMWB) ? r_mdr : r_aluout;
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (mem_ready) begin
                    r_ir <= mem_rdata;
                    r_pc <= r_pc + 32'd4;
                end
                S_DECODE: begin
                    r_a      <= r_rf[r_ir[25:21]];
                    r_b      <= r_rf[r_ir[20:16]];
                    r_aluout <= r_pc + (w_simm << 2);
                end
                S_MEMADR, S_ADDIEX: r_aluout <= w_addr;
                S_MEMRD:  if (mem_ready) r_mdr <= mem_rdata;
                S_EXEC:   r_aluout <= w_alu;
                S_BRANCH: if (r_a == r_b) r_pc <= r_aluout;
                S_JUMP:   r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                default:  ;
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (w_rf_we && w_rf_wa != 5'd0) begin
            r_rf[w_rf_wa] <= w_rf_wd;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: ISA-level reference interpreter predicts every bus access;
// a negedge monitor pops the scoreboard on each completed access and compares.
module tb_mips_multicycle_core;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic        mem_re, mem_we, mem_ready, halt;
    mips_multicycle_core #(.ADDR_WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clock(clock), .reset(reset), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halt(halt), .pc(pc)
    );
    always #5 clock = ~clock;
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        int          delta;
        int          hold;
    } exp_t;
    exp_t        exp_q [$];
    logic [31:0] mem   [1024];
    logic [31:0] m_mem [1024];
    logic [31:0] m_reg [32];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          strict = 1'b0;
    bit          fixed = 1'b1;
    bit          timed = 1'b0;
    int          wf = 0;
    int          wd = 0;
    always @(posedge clock) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask
    function automatic logic [31:0] ri(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction
    function automatic logic [31:0] ii(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction
    function automatic logic [31:0] jmp(input int idx);
        logic [31:0] t;
        t = RST_PC + 32'(4 * idx);
        return {6'h02, t[27:2]};
    endfunction
    function automatic bit is_data(input logic [31:0] a, input logic we);
        return we || a < RST_PC || a >= 32'h800;
    endfunction
    // Memory responder: picks a wait count per access, ready toggles randomly when idle.
    initial begin
        int wcnt, cur;
        mem_ready = 1'b0;
        mem_rdata = '0;
        wcnt = 0;
        cur = 0;
        forever begin
            @(posedge clock);
            #2;
            if (reset || !(mem_re || mem_we)) begin
                wcnt = 0;
                mem_ready = 1'($urandom_range(0, 1));
            end else begin
                if (wcnt == 0) cur = !fixed ? int'($urandom_range(0, 3)) : (is_data(mem_addr, mem_we) ? wd : wf);
                mem_ready = (wcnt >= cur);
                wcnt = mem_ready ? 0 : wcnt + 1;
            end
            mem_rdata = mem[mem_addr[11:2]];
        end
    end
    initial begin
        logic [31:0] p_addr, p_wdata;
        logic        p_we;
        int          run, last;
        bit          has_last;
        exp_t        e;
        run = 0;
        last = 0;
        has_last = 1'b0;
        p_addr = '0;
        p_wdata = '0;
        p_we = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                run = 0;
                has_last = 1'b0;
            end else begin
                if (mem_re && mem_we) check("re_we_exclusive", 32'(mem_we), 32'd0);
                if (mem_re || mem_we) begin
                    if (run > 0) begin
                        check("stable_addr", mem_addr, p_addr);
                        check("stable_we", 32'(mem_we), 32'(p_we));
                        if (mem_we) check("stable_wdata", mem_wdata, p_wdata);
                    end
                    run++;
                    p_addr = mem_addr;
                    p_we = mem_we;
                    p_wdata = mem_wdata;
                    if (mem_ready) begin
                        if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("acc_we", 32'(mem_we), 32'(e.we));
                            check("acc_addr", mem_addr, e.addr);
                            if (e.we) check("acc_wdata", mem_wdata, e.data);
                            if (timed) begin
                                if (has_last && e.delta >= 0) check("acc_cycles", cyc - last, e.delta);
                                check("acc_hold", run, e.hold);
                            end
                        end else if (strict) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL extra_access: got addr %h we %0b, expected no access", mem_addr, mem_we);
                        end
                        last = cyc;
                        has_last = 1'b1;
                        run = 0;
                    end
                end
            end
        end
    end
    function automatic void push(input bit we, input logic [31:0] addr, input logic [31:0] data, input int d, input int w);
        exp_t e;
        e.we = we;
        e.addr = addr;
        e.data = data;
        e.delta = d < 0 ? -1 : d + w;
        e.hold = w + 1;
        exp_q.push_back(e);
    endfunction
    function automatic void wreg(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_reg[r] = v;
    endfunction
    // Instruction-set interpreter: d is the spec's cycle count from the previous access.
    task automatic run_model(input logic [31:0] loop_addr);
        logic [31:0] p, ir, a, b, simm, ea, res;
        logic [5:0]  op;
        int          d, seen;
        bit          stop;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        for (int i = 0; i < 1024; i++) m_mem[i] = mem[i];
        p = RST_PC;
        d = -1;
        seen = 0;
        res = '0;
        for (int step = 0; step < 3000; step++) begin
            push(1'b0, p, '0, d, wf);
            if (p == loop_addr) seen++;
            if (seen >= 3) break;
            ir = m_mem[p[11:2]];
            p = p + 32'd4;
            a = m_reg[ir[25:21]];
            b = m_reg[ir[20:16]];
            simm = {{16{ir[15]}}, ir[15:0]};
            ea = a + simm;
            op = ir[31:26];
            stop = 1'b0;
            if (op == 6'h00) begin
                case (ir[5:0])
                    6'h20:   res = a + b;
                    6'h22:   res = a - b;
                    6'h24:   res = a & b;
                    6'h25:   res = a | b;
                    6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: stop = 1'b1;
                endcase
                if (!stop) wreg(ir[15:11], res);
                d = 4;
            end else if (op == 6'h08) begin
                wreg(ir[20:16], ea);
                d = 4;
            end else if (op == 6'h23 && ea[1:0] == 2'b00) begin
                push(1'b0, ea, '0, 3, wd);
                wreg(ir[20:16], m_mem[ea[11:2]]);
                d = 2;
            end else if (op == 6'h2B && ea[1:0] == 2'b00) begin
                push(1'b1, ea, b, 3, wd);
                m_mem[ea[11:2]] = b;
                d = 1;
            end else if (op == 6'h04) begin
                if (a == b) p = p + (simm << 2);
                d = 3;
            end else if (op == 6'h02) begin
                p = {p[31:28], ir[25:0], 2'b00};
                d = 3;
            end else begin
                stop = 1'b1;
            end
            if (stop) break;
        end
    endtask
    task automatic prog_clear();
        for (int i = 0; i < 1024; i++) mem[i] = (i >= 64 && i < 512) ? 32'h0 : $urandom;
    endtask
    task automatic pw(input int i, input logic [31:0] w);
        mem[64 + i] = w;
    endtask
    function automatic logic [31:0] rand_ins(input int i);
        logic [5:0] fns [5];
        int k;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        k = $urandom_range(0, 5);
        case (k)
            0: return ii(6'h08, $urandom_range(0, 7), $urandom_range(1, 7), 16'($urandom));
            1: return ri($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 7), fns[$urandom_range(0, 4)]);
            2: return ii(6'h23, 0, $urandom_range(1, 7), 16'(32'h800 + 4 * $urandom_range(0, 15)));
            3: return ii(6'h2B, 0, $urandom_range(0, 7), 16'(32'h800 + 4 * $urandom_range(0, 15)));
            4: return ii(6'h04, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom_range(0, 3)));
            default: return jmp(i + 1 + int'($urandom_range(0, 3)));
        endcase
    endfunction
    task automatic do_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        strict = 1'b0;
        @(negedge clock);
        check("rst_re", 32'(mem_re), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        exp_q.delete();
    endtask
    task automatic release_run();
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("first_re", 32'(mem_re), 32'd1);
        check("first_addr", mem_addr, RST_PC);
        check("first_halt", 32'(halt), 32'd0);
    endtask
    task automatic drain(input string name, input int limit);
        int c;
        c = 0;
        while (exp_q.size() > 0 && c < limit) begin
            @(posedge clock);
            c++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [31:0] bad [3];
        logic [31:0] keep;
        int c;
        // Directed arithmetic program, zero wait states, cycle-exact.
        do_reset();
        prog_clear();
        pw(0, ii(6'h08, 0, 1, 16'd5));
        pw(1, ii(6'h08, 0, 2, 16'hFFFD));
        pw(2, ri(1, 2, 3, 6'h20));
        pw(3, ri(2, 1, 4, 6'h2A));
        pw(4, ii(6'h2B, 0, 3, 16'h0800));
        pw(5, ii(6'h2B, 0, 4, 16'h0804));
        pw(6, ii(6'h04, 1, 2, 16'd4));
        pw(7, ii(6'h2B, 0, 1, 16'h0808));
        pw(8, ii(6'h23, 0, 5, 16'h0808));
        pw(9, ri(5, 2, 6, 6'h22));
        pw(10, ii(6'h2B, 0, 6, 16'h080C));
        pw(11, jmp(13));
        pw(12, ii(6'h2B, 0, 0, 16'h080C));
        pw(13, ii(6'h04, 1, 1, 16'hFFFF));
        fixed = 1'b1; timed = 1'b1; wf = 0; wd = 0;
        run_model(RST_PC + 32'd52);
        release_run();
        drain("directed_drain", 500);
        check("add_result", mem[32'h200], 32'd2);
        check("slt_result", mem[32'h201], 32'd1);
        check("fallthrough_store", mem[32'h202], 32'd5);
        check("sub_result", mem[32'h203], 32'd8);
        // Store/load with three data wait states.
        do_reset();
        prog_clear();
        pw(0, ii(6'h08, 0, 1, 16'd5));
        pw(1, ii(6'h2B, 0, 1, 16'd8));
        pw(2, ii(6'h23, 0, 5, 16'd8));
        pw(3, ii(6'h2B, 0, 5, 16'h0800));
        pw(4, ii(6'h04, 0, 0, 16'hFFFF));
        fixed = 1'b1; timed = 1'b1; wf = 0; wd = 3;
        run_model(RST_PC + 32'd16);
        release_run();
        drain("waitstate_drain", 500);
        check("sw_word", mem[2], 32'd5);
        check("lw_result", mem[32'h200], 32'd5);
        // Random programs.
        for (int t = 0; t < 24; t++) begin
            do_reset();
            prog_clear();
            for (int i = 0; i < 20; i++) pw(i, rand_ins(i));
            for (int k = 1; k < 8; k++) pw(19 + k, ii(6'h2B, 0, k, 16'(32'h840 + 4 * k)));
            pw(27, ii(6'h04, 0, 0, 16'hFFFF));
            fixed = t[0]; timed = t[0];
            wf = $urandom_range(0, 2);
            wd = $urandom_range(0, 2);
            run_model(RST_PC + 32'd108);
            release_run();
            drain("random_drain", 5000);
        end
        // Illegal opcode, misaligned lw, unknown funct: all must halt quietly.
        bad = '{32'hFC00_0000, ii(6'h23, 0, 5, 16'd6), ri(1, 1, 9, 6'h21)};
        for (int v = 0; v < 3; v++) begin
            do_reset();
            prog_clear();
            pw(0, ii(6'h08, 0, 1, 16'd7));
            pw(1, ii(6'h2B, 0, 1, 16'h0800));
            pw(2, bad[v]);
            pw(3, ii(6'h2B, 0, 1, 16'h0804));
            pw(4, ii(6'h04, 0, 0, 16'hFFFF));
            fixed = 1'b0; timed = 1'b0;
            run_model(RST_PC + 32'd16);
            strict = 1'b1;
            release_run();
            drain("halt_drain", 2000);
            repeat (20) @(negedge clock);
            check("halt_set", 32'(halt), 32'd1);
            check("halt_no_re", 32'(mem_re), 32'd0);
            check("halt_no_we", 32'(mem_we), 32'd0);
        end
        // Reset while a store is stalled.
        do_reset();
        prog_clear();
        pw(0, ii(6'h08, 0, 1, 16'd5));
        pw(1, ii(6'h2B, 0, 1, 16'h0800));
        pw(2, ii(6'h04, 0, 0, 16'hFFFF));
        keep = 32'hDEAD_BEEF;
        mem[32'h200] = keep;
        fixed = 1'b1; timed = 1'b0; wf = 0; wd = 1000;
        push(1'b0, RST_PC, '0, -1, 0);
        push(1'b0, RST_PC + 32'd4, '0, -1, 0);
        release_run();
        c = 0;
        while (!mem_we && c < 100) begin
            @(negedge clock);
            c++;
        end
        check("memwr_reached", 32'(mem_we), 32'd1);
        repeat (2) @(negedge clock);
        check("pre_reset_fetches", exp_q.size(), 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        wd = 0;
        @(negedge clock);
        check("rst_mid_we", 32'(mem_we), 32'd0);
        @(posedge clock);
        #1;
        check("no_write_on_reset", mem[32'h200], keep);
        push(1'b0, RST_PC, '0, -1, 0);
        release_run();
        drain("post_reset_fetch", 100);
        check("still_no_write", mem[32'h200], keep);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
